// File: rtl/alu_resp_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_resp_tx                                                  |
// | Description : ALU-side serial response transmitter. Latches a finished    |
// |               result (C, flags) or an error indication, builds the        |
// |               response packet (CRC3 for results, even parity for errors)  |
// |               and shifts it out on sout as 11-bit frames:                 |
// |               start '0', type bit (0 data / 1 ctl), 8 data bits MSB       |
// |               first, stop '1'. The line idles at '1'.                     |
// | Parameters  : BIT_CYCLES - clocks per serial bit (>= 1)                    |
// |               IFG_BITS   - idle bits between frames (IFG builds only)     |
// | Macro       : ALU_RESP_TX_IFG_EN - when defined, IFG_BITS*BIT_CYCLES idle  |
// |               clocks follow every stop bit except the packet's last one.  |
// | Ports       : clk, rst (async, active-high)                                |
// |               req_valid/req_ready   - request handshake                    |
// |               req_err               - 1 = error packet, 0 = result packet  |
// |               req_c, req_flags      - result payload                       |
// |               req_err_flags         - error payload                        |
// |               sout                  - serial output                        |
// |               busy                  - packet in progress (= ~req_ready)    |
// |               done                  - 1-cycle pulse in last stop-bit clock |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module alu_resp_tx #(
  parameter int BIT_CYCLES = 1,
  parameter int IFG_BITS   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_err,
  input  logic [31:0] req_c,
  input  logic [3:0]  req_flags,
  input  logic [5:0]  req_err_flags,
  output logic        sout,
  output logic        busy,
  output logic        done
);

  localparam int            CW       = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);

`ifdef ALU_RESP_TX_IFG_EN
  localparam int            IFG_LEN  = IFG_BITS * BIT_CYCLES;
  localparam int            IW       = (IFG_LEN > 1) ? $clog2(IFG_LEN) : 1;
  localparam logic [IW-1:0] IFG_LAST = IW'(IFG_LEN - 1);
`endif

  // Elaboration-time guard against illegal configurations.
  if (BIT_CYCLES < 1 || IFG_BITS < 0) begin : g_bad_param
    $error("alu_resp_tx: BIT_CYCLES must be >= 1 and IFG_BITS >= 0");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_TYPE,
    S_DATA,
    S_STOP
`ifdef ALU_RESP_TX_IFG_EN
    , S_IFG
`endif
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cyc_cnt;
  logic [2:0]    bit_cnt;
  logic [2:0]    frame_cnt;
  logic          is_err;
  logic [31:0]   c_q;
  logic [3:0]    flags_q;
  logic [5:0]    err_flags_q;
`ifdef ALU_RESP_TX_IFG_EN
  logic [IW-1:0] ifg_cnt;
`endif

  logic          accept;
  logic          bit_end;
  logic          last_frame;
  logic [2:0]    crc;
  logic [7:0]    tx_byte;
  logic          type_bit;

  // Serial CRC3, polynomial x^3+x+1, MSB first, zero init, no final XOR.
  function automatic logic [2:0] crc3(input logic [36:0] v);
    logic [2:0] r;
    logic       fb;
    r = 3'b000;
    for (int i = 36; i >= 0; i--) begin
      fb = r[2] ^ v[i];
      r  = {r[1:0], 1'b0} ^ (fb ? 3'b011 : 3'b000);
    end
    return r;
  endfunction

  assign accept     = req_valid && (state == S_IDLE);
  assign bit_end    = (cyc_cnt == CYC_LAST);
  assign last_frame = is_err ? (frame_cnt == 3'd0) : (frame_cnt == 3'd4);
  // Derived from the latched payload, so it is stable for the whole packet.
  assign crc        = crc3({c_q, 1'b0, flags_q});
  assign type_bit   = is_err | (frame_cnt == 3'd4);

  always_comb begin
    tx_byte = 8'h00;
    if (is_err) begin
      // Parity bit chosen so the whole byte carries an even number of ones.
      tx_byte = {1'b1, err_flags_q, ^{1'b1, err_flags_q}};
    end else begin
      case (frame_cnt)
        3'd0:    tx_byte = c_q[31:24];
        3'd1:    tx_byte = c_q[23:16];
        3'd2:    tx_byte = c_q[15:8];
        3'd3:    tx_byte = c_q[7:0];
        default: tx_byte = {1'b0, flags_q, crc};
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and outputs
  always_comb begin
    state_nxt = state;
    sout      = 1'b1;
    done      = 1'b0;
    req_ready = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (accept) state_nxt = S_START;
      end
      S_START: begin
        sout = 1'b0;
        if (bit_end) state_nxt = S_TYPE;
      end
      S_TYPE: begin
        sout = type_bit;
        if (bit_end) state_nxt = S_DATA;
      end
      S_DATA: begin
        sout = tx_byte[3'd7 - bit_cnt];
        if (bit_end && (bit_cnt == 3'd7)) state_nxt = S_STOP;
      end
      S_STOP: begin
        if (bit_end) begin
          if (last_frame) begin
            done      = 1'b1;
            state_nxt = S_IDLE;
          end else begin
`ifdef ALU_RESP_TX_IFG_EN
            state_nxt = (IFG_LEN > 0) ? S_IFG : S_START;
`else
            state_nxt = S_START;
`endif
          end
        end
      end
`ifdef ALU_RESP_TX_IFG_EN
      S_IFG: begin
        if (ifg_cnt == IFG_LAST) state_nxt = S_START;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = ~req_ready;

  // Counters and request latches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt     <= '0;
      bit_cnt     <= 3'd0;
      frame_cnt   <= 3'd0;
      is_err      <= 1'b0;
      c_q         <= 32'h0;
      flags_q     <= 4'h0;
      err_flags_q <= 6'h0;
    end else begin
      if (accept) begin
        is_err      <= req_err;
        c_q         <= req_c;
        flags_q     <= req_flags;
        err_flags_q <= req_err_flags;
        frame_cnt   <= 3'd0;
        bit_cnt     <= 3'd0;
      end

      // The cycle counter only runs inside a bit; it rests at zero in
      // IDLE and during the inter-frame gap so every bit starts aligned.
      if (state == S_START || state == S_TYPE || state == S_DATA || state == S_STOP) begin
        cyc_cnt <= bit_end ? '0 : cyc_cnt + 1'b1;
      end else begin
        cyc_cnt <= '0;
      end

      // Wraps 7 -> 0 naturally, ready for the next frame.
      if (state == S_DATA && bit_end) begin
        bit_cnt <= bit_cnt + 3'd1;
      end

      if (state == S_STOP && bit_end && !last_frame) begin
        frame_cnt <= frame_cnt + 3'd1;
      end
    end
  end

`ifdef ALU_RESP_TX_IFG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifg_cnt <= '0;
    end else if (state == S_IFG && ifg_cnt != IFG_LAST) begin
      ifg_cnt <= ifg_cnt + 1'b1;
    end else begin
      ifg_cnt <= '0;
    end
  end
`endif

endmodule
`default_nettype wire
